// File: rtl/rt_req_issuer_if.sv
// rtl/rt_req_issuer_if.sv - request, bank and response signal bundle for rt_req_issuer
interface rt_req_issuer_if #(
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_is_write;
    logic [6:0]                  req_reg_id;
    logic [4:0]                  req_queue_id;
    logic [DATA_W-1:0]           req_wdata;

    logic [NUM_BANKS-1:0]        bank_read_req;
    logic [NUM_BANKS-1:0]        bank_write_req;
    logic [6:0]                  bank_reg_id;
    logic [4:0]                  bank_queue_id;
    logic [DATA_W-1:0]           bank_write_data;
    logic [NUM_BANKS*DATA_W-1:0] bank_read_data;
    logic [NUM_BANKS-1:0]        bank_ack;
    logic [NUM_BANKS-1:0]        bank_alignment_err;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [4:0]                  resp_queue_id;
    logic                        resp_is_write;
    logic [DATA_W-1:0]           resp_data;
    logic                        resp_err;
    logic                        resp_timeout;
    logic                        busy;

    modport master (
        input  req_valid, req_is_write, req_reg_id, req_queue_id, req_wdata,
        output req_ready,
        output bank_read_req, bank_write_req, bank_reg_id, bank_queue_id, bank_write_data,
        input  bank_read_data, bank_ack, bank_alignment_err,
        output resp_valid, resp_queue_id, resp_is_write, resp_data, resp_err, resp_timeout,
        input  resp_ready,
        output busy
    );

    modport slave (
        output req_valid, req_is_write, req_reg_id, req_queue_id, req_wdata,
        input  req_ready,
        input  bank_read_req, bank_write_req, bank_reg_id, bank_queue_id, bank_write_data,
        output bank_read_data, bank_ack, bank_alignment_err,
        input  resp_valid, resp_queue_id, resp_is_write, resp_data, resp_err, resp_timeout,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/rt_req_issuer.sv
// rtl/rt_req_issuer.sv - register-bank request issuer: FIFO, one outstanding request, bank select by reg_id % NUM_BANKS
// Optional: RT_ALIGN_PRECHECK_EN rejects misaligned requests in IDLE without touching a bank.
module rt_req_issuer #(
    parameter int DATA_W      = 64,
    parameter int NUM_BANKS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    rt_req_issuer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              is_write;
        logic [6:0]        reg_id;
        logic [4:0]        queue_id;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    state_t            r_state;
    state_t            w_state_nx;
    entry_t            r_fifo [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    entry_t            r_cap;
    logic [CW-1:0]     r_cnt;
    logic [4:0]        r_resp_queue_id;
    logic              r_resp_is_write;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic              r_resp_timeout;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    entry_t            w_head;
    logic [BW-1:0]     w_bank;
    logic              w_ack;
    logic              w_aerr;
    logic [DATA_W-1:0] w_rdata;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = bus.req_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];

    assign w_bank  = r_cap.reg_id[BW-1:0];
    assign w_ack   = bus.bank_ack[w_bank];
    assign w_aerr  = bus.bank_alignment_err[w_bank];
    assign w_rdata = bus.bank_read_data[int'(w_bank) * DATA_W +: DATA_W];

`ifdef RT_ALIGN_PRECHECK_EN
    logic w_head_legal;
    assign w_head_legal = (w_head.queue_id[2:0] == {1'b0, w_head.reg_id[1:0]});
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= '{is_write: bus.req_is_write, reg_id: bus.req_reg_id,
                                          queue_id: bus.req_queue_id, wdata: bus.req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
`ifdef RT_ALIGN_PRECHECK_EN
                    w_state_nx = w_head_legal ? S_ISSUE : S_RESP;
`else
                    w_state_nx = S_ISSUE;
`endif
                end
            end
            S_ISSUE: w_state_nx = S_WAIT;
            S_WAIT: begin
                if (w_ack || (r_cnt >= CNT_LAST)) begin
                    w_state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cap           <= '0;
            r_cnt           <= '0;
            r_resp_queue_id <= '0;
            r_resp_is_write <= 1'b0;
            r_resp_data     <= '0;
            r_resp_err      <= 1'b0;
            r_resp_timeout  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cap    <= w_head;
            end
            case (r_state)
`ifdef RT_ALIGN_PRECHECK_EN
                S_IDLE: begin
                    if (w_pop && !w_head_legal) begin
                        r_resp_queue_id <= w_head.queue_id;
                        r_resp_is_write <= w_head.is_write;
                        r_resp_data     <= '0;
                        r_resp_err      <= 1'b1;
                        r_resp_timeout  <= 1'b0;
                    end
                end
`endif
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (w_ack) begin
                        r_resp_queue_id <= r_cap.queue_id;
                        r_resp_is_write <= r_cap.is_write;
                        r_resp_data     <= (!r_cap.is_write && !w_aerr) ? w_rdata : '0;
                        r_resp_err      <= w_aerr;
                        r_resp_timeout  <= 1'b0;
                    end else begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt >= CNT_LAST) begin
                            r_resp_queue_id <= r_cap.queue_id;
                            r_resp_is_write <= r_cap.is_write;
                            r_resp_data     <= '0;
                            r_resp_err      <= 1'b1;
                            r_resp_timeout  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and broadcasts exist only in ISSUE; reset drops them through r_state.
    always_comb begin
        bus.bank_read_req   = '0;
        bus.bank_write_req  = '0;
        bus.bank_reg_id     = '0;
        bus.bank_queue_id   = '0;
        bus.bank_write_data = '0;
        bus.resp_valid      = (r_state == S_RESP);
        if (r_state == S_ISSUE) begin
            bus.bank_read_req[w_bank]  = !r_cap.is_write;
            bus.bank_write_req[w_bank] = r_cap.is_write;
            bus.bank_reg_id            = r_cap.reg_id;
            bus.bank_queue_id          = r_cap.queue_id;
            bus.bank_write_data        = r_cap.wdata;
        end
    end

    assign bus.req_ready     = !w_full;
    assign bus.resp_queue_id = r_resp_queue_id;
    assign bus.resp_is_write = r_resp_is_write;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_timeout  = r_resp_timeout;
    assign bus.busy          = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_rt_req_issuer.sv
// tb/tb_rt_req_issuer.sv - directed scoreboard bench for rt_req_issuer with a registered bank model
module tb_rt_req_issuer;
    localparam int DATA_W = 64;
    localparam int NB     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rt_req_issuer_if #(.DATA_W(DATA_W), .NUM_BANKS(NB)) bus ();

    rt_req_issuer #(.DATA_W(DATA_W), .NUM_BANKS(NB), .FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  qid;
        logic        is_write;
        logic [63:0] data;
        logic        err;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic        bank_noack = 1'b0;
    logic [3:0]  late_ack = 4'b0;
    logic [3:0]  m_ack = 4'b0;
    logic [3:0]  m_err = 4'b0;
    logic [63:0] bank_val [4];

    // Bank model: acks one cycle after a strobe, flags misalignment itself.
    always @(posedge clk) begin
        logic [3:0] s;
        s = bus.bank_read_req | bus.bank_write_req;
        if (bank_noack) begin
            m_ack <= 4'b0;
            m_err <= 4'b0;
        end else begin
            m_ack <= s;
            m_err <= s & {4{(int'(bus.bank_queue_id) % 8) != (int'(bus.bank_reg_id) % 4)}};
        end
    end
    assign bus.bank_ack           = m_ack | late_ack;
    assign bus.bank_alignment_err = m_err;
    assign bus.bank_read_data     = {bank_val[3], bank_val[2], bank_val[1], bank_val[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic w, input int rid, input int qid);
        exp_t e;
        logic mis;
        mis        = (qid % 8) != (rid % 4);
        e.qid      = 5'(qid);
        e.is_write = w;
        e.err      = mis;
        e.to       = 1'b0;
        e.data     = (w || mis) ? 64'h0 : bank_val[rid % 4];
        return e;
    endfunction

    task automatic drive_req(input logic w, input int rid, input int qid, input logic [63:0] d);
        bus.req_valid    = 1'b1;
        bus.req_is_write = w;
        bus.req_reg_id   = 7'(rid);
        bus.req_queue_id = 5'(qid);
        bus.req_wdata    = d;
    endtask

    task automatic push1(input logic w, input int rid, input int qid, input logic [63:0] d, input exp_t e);
        drive_req(w, rid, qid, d);
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.resp_valid, 1);
        if (bus.resp_valid === 1'b1) begin
            chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_qid"},   bus.resp_queue_id, e.qid);
                chk({tag, "_iswr"},  bus.resp_is_write, e.is_write);
                chk({tag, "_data"},  bus.resp_data, e.data);
                chk({tag, "_err"},   bus.resp_err, e.err);
                chk({tag, "_tmo"},   bus.resp_timeout, e.to);
            end
            if (bus.resp_ready === 1'b1) @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        int   lat;
        bank_val[0] = 64'hA0A0_0000_0000_00A0;
        bank_val[1] = 64'h0000_0000_DEAD_BEEF;
        bank_val[2] = 64'h2222_3333_4444_5555;
        bank_val[3] = 64'h3333_0000_1111_3333;
        bus.req_valid    = 1'b0;
        bus.req_is_write = 1'b0;
        bus.req_reg_id   = '0;
        bus.req_queue_id = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.bank_read_req, bus.bank_write_req}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write reg 5 qid 1: strobe at N+2 for one cycle, response at N+4.
        push1(1'b1, 5, 1, 64'hDEAD_BEEF, mk(1'b1, 5, 1));
        @(negedge clk);
        chk("t1_wr_strobe", bus.bank_write_req, 4'b0010);
        chk("t1_rd_strobe", bus.bank_read_req, 4'b0000);
        chk("t1_reg_id", bus.bank_reg_id, 5);
        chk("t1_wdata", bus.bank_write_data, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_strobe_1cyc", bus.bank_write_req, 4'b0000);
        @(negedge clk);
        chk("t1_latency", bus.resp_valid, 1);
        check_resp("t1");

        push1(1'b0, 5, 1, 64'h0, mk(1'b0, 5, 1));
        @(negedge clk);
        chk("t2_rd_strobe", bus.bank_read_req, 4'b0010);
        @(negedge clk);
        chk("t2_strobe_1cyc", bus.bank_read_req, 4'b0000);
        @(negedge clk);
        chk("t2_latency", bus.resp_valid, 1);
        check_resp("t2");

        push1(1'b0, 6, 1, 64'h0, mk(1'b0, 6, 1));
        @(negedge clk);
`ifdef RT_ALIGN_PRECHECK_EN
        chk("t3_no_strobe", bus.bank_read_req, 4'b0000);
`else
        chk("t3_rd_strobe", bus.bank_read_req, 4'b0100);
`endif
        check_resp("t3");

        // No ack: 15 WAIT cycles, so response 18 cycles after the push.
        bank_noack = 1'b1;
        e      = mk(1'b1, 3, 3);
        e.err  = 1'b1;
        e.to   = 1'b1;
        push1(1'b1, 3, 3, 64'h1234, e);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_timeout_latency", lat, 18);
        check_resp("t4");
        bank_noack = 1'b0;
        push1(1'b0, 2, 2, 64'h0, mk(1'b0, 2, 2));
        check_resp("t4_after");

        // Stalled consumer: 1 in RESP, 4 queued, 6th refused.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_req(1'(i % 2), i, (i % 4) + 8 * (i / 4), 64'(i + 100));
            chk($sformatf("t5_req_ready_%0d", i), bus.req_ready, (i < 5) ? 1 : 0);
            if (i < 5) sb.push_back(mk(1'(i % 2), i, (i % 4) + 8 * (i / 4)));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_hold_valid_%0d", k), bus.resp_valid, 1);
            chk($sformatf("t5_hold_qid_%0d", k), bus.resp_queue_id, sb[0].qid);
            chk($sformatf("t5_hold_data_%0d", k), bus.resp_data, sb[0].data);
            @(negedge clk);
        end
        chk("t5_full", bus.req_ready, 0);
        chk("t5_busy", bus.busy, 1);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) check_resp($sformatf("t5_r%0d", i));
        chk("t5_sb_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        chk("t5_idle", bus.busy, 0);

        // Reset while waiting for a bank that never answers.
        bank_noack = 1'b1;
        push1(1'b0, 1, 1, 64'h0, mk(1'b0, 1, 1));
        repeat (2) @(negedge clk);
        chk("t6_busy_pre", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_strobes", {bus.bank_read_req, bus.bank_write_req}, 0);
        chk("t6_resp_valid", bus.resp_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_req_ready", bus.req_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n      = 1'b1;
        bank_noack = 1'b0;
        late_ack   = 4'b0010;
        @(negedge clk);
        late_ack = 4'b0000;
        repeat (3) @(negedge clk);
        chk("t6_late_ack_resp", bus.resp_valid, 0);
        chk("t6_late_ack_busy", bus.busy, 0);
        push1(1'b0, 7, 3, 64'h0, mk(1'b0, 7, 3));
        check_resp("t6_recover");
        chk("end_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rt_req_issuer.md
Name: rt_req_issuer

Overview:
- Initiator side of the register-bank tile protocol: accepts block read/write register requests from the global control / operand network and issues them to the correct one of 4 register banks.
- Bank is selected by reg_id % 4. The issuer drives one-cycle req pulses, collects the bank ack/alignment_err/read_data, and returns one response per request.
- One request outstanding at a time. Requests are buffered in a small FIFO; responses use a valid/ready handshake.

Parameters:
- DATA_W, 64, width of reg_data_t payload
- NUM_BANKS, 4, register banks; bank index = reg_id % NUM_BANKS
- FIFO_DEPTH, 4, request buffer entries (power of 2)
- ACK_TIMEOUT, 15, cycles waited for bank ack before error

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= !full)
- req_is_write  in  1  1=write, 0=read
- req_reg_id  in  7  G[0-127]
- req_queue_id  in  5  R/W[0-31]
- req_wdata  in  DATA_W  write payload
- bank_read_req  out  NUM_BANKS  one-hot read strobe
- bank_write_req  out  NUM_BANKS  one-hot write strobe
- bank_reg_id  out  7  broadcast reg id
- bank_queue_id  out  5  broadcast queue id
- bank_write_data  out  DATA_W  broadcast write data
- bank_read_data  in  NUM_BANKS*DATA_W  per-bank read data, bank b at [b*DATA_W +: DATA_W]
- bank_ack  in  NUM_BANKS  per-bank ack
- bank_alignment_err  in  NUM_BANKS  per-bank alignment error
- resp_valid  out  1  response held
- resp_ready  in  1  consumer accepts
- resp_queue_id  out  5  queue id of completed request
- resp_is_write  out  1  echo of request type
- resp_data  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  alignment error or timeout
- resp_timeout  out  1  error cause was timeout
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: all outputs 0 except req_ready=1. FIFO emptied, FSM=IDLE, timeout counter=0. Reset asserted mid-operation aborts immediately: bank strobes drop asynchronously and the in-flight request is lost with no response.
- FIFO push on req_valid && req_ready. There is no bypass: a request pushed in cycle N is popped at the earliest in cycle N+1. Pop and push in the same cycle are allowed when not full. req_ready = !full, so push is refused when full even if a pop occurs that cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop the head into a capture register and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - b = reg_id[1:0].
  - Drive bank_read_req[b] or bank_write_req[b] high, plus bank_reg_id, bank_queue_id and bank_write_data from the capture register.
  - Clear the counter and go to WAIT.
  - Strobes are low in every other state.
- WAIT: bank b acks on the cycle after ISSUE (registered bank).
  - bank_ack[b]=1: latch resp_err=bank_alignment_err[b]. resp_data=bank_read_data[b] only for a read without error, else 0. Go to RESP.
  - Acks on other banks, and acks received outside WAIT, are ignored.
  - Counter increments each WAIT cycle without ack. When the counter reaches ACK_TIMEOUT with no ack, set resp_err=1 and resp_timeout=1 and go to RESP. Counter width is $clog2(ACK_TIMEOUT+1); it saturates and never wraps.
- RESP: resp_valid=1, and all resp_* fields are held stable until resp_ready. On resp_valid && resp_ready, clear resp_valid and go to IDLE. The next pop happens in IDLE, so minimum issue spacing is 4 cycles per request.
- Latency with resp_ready=1 and the FIFO previously empty: push at N, pop N+1, ISSUE N+2, ack N+3, resp_valid N+4.
- Alignment rule: legal iff (queue_id % 8) == (reg_id % 4). Queue ids with queue_id % 8 >= 4 are therefore always illegal.

Optional Feature:
- Macro: RT_ALIGN_PRECHECK_EN.
- Defined: in IDLE, the popped entry is checked with the alignment rule. If illegal, ISSUE and WAIT are skipped and the FSM goes directly to RESP with resp_err=1, resp_timeout=0 and resp_data=0. No bank strobe is driven.
- Undefined: every request is issued and the error comes only from bank_alignment_err.

Test Plan:
- Write reg 5, qid 1, data 0xDEAD_BEEF, resp_ready=1 -> bank_write_req=4'b0010 for exactly 1 cycle with bank_reg_id=5. Bank model acks next cycle -> resp_valid, resp_err=0, resp_data=0, resp_queue_id=1.
- Read reg 5, qid 1, bank 1 returns 0xDEAD_BEEF -> bank_read_req=4'b0010 one cycle; resp_data=0xDEAD_BEEF at N+4 after push.
- Read reg 6, qid 1 (misaligned). With RT_ALIGN_PRECHECK_EN -> no strobe, resp_err=1. Without it -> bank_read_req=4'b0100, bank returns ack + alignment_err -> resp_err=1, resp_data=0.
- Bank never acks -> after 15 WAIT cycles resp_err=1, resp_timeout=1; the following request issues normally.
- resp_ready=0, push 6 requests back-to-back -> 1 popped and held in RESP, 4 in FIFO, req_ready=0 and 6th not accepted. Release resp_ready -> 5 responses delivered in push order, fields stable while stalled.
- Assert rst_n=0 during WAIT -> strobes and resp_valid low immediately, busy=0, req_ready=1. A late ack after reset is ignored.
